// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: opcodes, ALU ops, status error
// codes, completion-queue entry layout and small decode helpers.
package wb_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_ADD  = 3'd1;
  localparam logic [2:0] ERR_ADDI = 3'd2;
  localparam logic [2:0] ERR_SUB  = 3'd3;
  localparam logic [2:0] ERR_MUL  = 3'd4;
  localparam logic [2:0] ERR_DIV  = 3'd5;

  // Completion-queue entry at the default configuration (32-bit data,
  // 32 registers); wb_cq stores the same three fields at its parameter widths.
  typedef struct packed {
    logic        valid;
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_cq_entry_t;

  // R-type mul/div finish through the multdiv channel, not the pipe.
  function automatic logic is_md_op(input logic [4:0] alu_op);
    return (alu_op == ALU_MUL) || (alu_op == ALU_DIV);
  endfunction

  // Status code reported when an overflow-capable instruction overflows;
  // ERR_NONE for instructions that cannot overflow.
  function automatic logic [2:0] ovf_code(input logic [4:0] opcode,
                                          input logic [4:0] alu_op);
    logic [2:0] code;
    code = ERR_NONE;
    if (opcode == OP_ADDI) begin
      code = ERR_ADDI;
    end else if (opcode == OP_RTYPE && alu_op == ALU_ADD) begin
      code = ERR_ADD;
    end else if (opcode == OP_RTYPE && alu_op == ALU_SUB) begin
      code = ERR_SUB;
    end else begin
      code = ERR_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/wb_cq.sv
// DEPTH-entry circular completion queue. Each entry can be squashed in place
// (valid cleared) by a younger pipe write to the same register; squashed
// entries still occupy a slot until popped. Exports a pending-destination mask.
module wb_cq
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  localparam int RW = $clog2(NREGS),
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [RW-1:0]    push_dest_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             squash_i,
  input  logic [RW-1:0]    squash_dest_i,
  output logic             head_valid_o,
  output logic [RW-1:0]    head_dest_o,
  output logic [WIDTH-1:0] head_data_o,
  output logic [CW-1:0]    count_o,
  output logic [NREGS-1:0] pending_o
);

  logic             valid_q [DEPTH];
  logic             valid_d [DEPTH];
  logic [RW-1:0]    dest_q  [DEPTH];
  logic [RW-1:0]    dest_d  [DEPTH];
  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [WIDTH-1:0] data_d  [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [NREGS-1:0] pending_s;
  logic             push_keep_s;

  // Next-state for entries, pointers and occupancy.
  always_comb begin
    // An entry pushed on the same edge as a pipe write to its register is
    // already stale, so it enters the queue squashed.
    push_keep_s = ~(squash_i && (push_dest_i == squash_dest_i));
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i]
                   & ~(squash_i && (dest_q[i] == squash_dest_i))
                   & ~(pop_i && (rd_ptr_q == AW'(i)));
      dest_d[i]  = dest_q[i];
      data_d[i]  = data_q[i];
      if (push_i && (wr_ptr_q == AW'(i))) begin
        valid_d[i] = push_keep_s;
        dest_d[i]  = push_dest_i;
        data_d[i]  = push_data_i;
      end else begin
        dest_d[i]  = dest_q[i];
      end
    end
    wr_ptr_d = push_i ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_i  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d  = count_q + (push_i ? CW'(1) : CW'(0)) - (pop_i ? CW'(1) : CW'(0));
  end

  // Queue state registers; reset discards every entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        dest_q[i]  <= '0;
        data_q[i]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        dest_q[i]  <= dest_d[i];
        data_q[i]  <= data_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // One-hot OR of live destinations; register 0 is never reported.
  always_comb begin
    pending_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_s = pending_s | (valid_q[i] ? (NREGS'(1) << dest_q[i]) : NREGS'(0));
    end
    pending_s[0] = 1'b0;
  end

  assign head_valid_o = valid_q[rd_ptr_q];
  assign head_dest_o  = dest_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
  assign count_o      = count_q;
  assign pending_o    = pending_s;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: decodes the W-stage instruction into one register-file
// write and merges it with multdiv completions through wb_cq.
// Port priority: pipe write > queue head > direct md bypass.
// Build option: define WB_EXCEPTION_EN to redirect overflow and md exceptions
// to STATUS_REG with error codes 1-5; otherwise those flags are ignored.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NREGS      = 32,
  parameter int DEPTH      = 4,
  parameter int TARGET_W   = 27,
  parameter int LINK_REG   = 31,
  parameter int STATUS_REG = 30,
  localparam int RW = $clog2(NREGS),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                pipe_valid,
  input  logic [4:0]          opcode,
  input  logic [4:0]          alu_op,
  input  logic [RW-1:0]       rd,
  input  logic [TARGET_W-1:0] target,
  input  logic [WIDTH-1:0]    d_in,
  input  logic [WIDTH-1:0]    o_in,
  input  logic                overflow,
  input  logic                md_valid,
  output logic                md_ready,
  input  logic [RW-1:0]       md_rd,
  input  logic [WIDTH-1:0]    md_result,
  input  logic                md_is_div,
  input  logic                md_exception,
  output logic                write_ctrl,
  output logic [RW-1:0]       write_reg,
  output logic [WIDTH-1:0]    write_data,
  output logic                loading,
  output logic [NREGS-1:0]    md_pending,
  output logic [CW-1:0]       queue_count
);

  logic             pipe_we_s;
  logic [RW-1:0]    pipe_dest_s;
  logic [WIDTH-1:0] pipe_data_s;
  logic [RW-1:0]    md_dest_s;
  logic [WIDTH-1:0] md_data_s;
  logic             md_fire_s;
  logic             cq_empty_s;
  logic             push_s;
  logic             pop_s;
  logic             sel_valid_s;
  logic [RW-1:0]    sel_dest_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             head_valid_s;
  logic [RW-1:0]    head_dest_s;
  logic [WIDTH-1:0] head_data_s;
  logic [CW-1:0]    cq_count_s;
  logic [NREGS-1:0] cq_pending_s;

`ifdef WB_EXCEPTION_EN
  logic [2:0]       ovf_code_s;
  logic             pipe_exc_s;
  assign ovf_code_s = ovf_code(opcode, alu_op);
  assign pipe_exc_s = overflow && (ovf_code_s != ERR_NONE);
`else
  logic unused_exc_s;
  assign unused_exc_s = ^{overflow, md_exception, md_is_div};
`endif

  // Decode the W-stage instruction into a pipe write request.
  always_comb begin
    pipe_we_s   = 1'b0;
    pipe_dest_s = rd;
    pipe_data_s = o_in;
    if (pipe_valid) begin
      case (opcode)
        OP_LW: begin
          pipe_we_s   = 1'b1;
          pipe_data_s = d_in;
        end
        OP_RTYPE: pipe_we_s = ~is_md_op(alu_op);
        OP_ADDI:  pipe_we_s = 1'b1;
        OP_JAL: begin
          pipe_we_s   = 1'b1;
          pipe_dest_s = RW'(LINK_REG);
        end
        OP_SETX: begin
          pipe_we_s   = 1'b1;
          pipe_dest_s = RW'(STATUS_REG);
          pipe_data_s = {{(WIDTH-TARGET_W){target[TARGET_W-1]}}, target};
        end
        default: pipe_we_s = 1'b0;
      endcase
`ifdef WB_EXCEPTION_EN
      pipe_dest_s = pipe_exc_s ? RW'(STATUS_REG) : pipe_dest_s;
      pipe_data_s = pipe_exc_s ? WIDTH'(ovf_code_s) : pipe_data_s;
`endif
    end else begin
      pipe_we_s = 1'b0;
    end
  end

  // Destination and data of an md completion, exceptions redirected if enabled.
  always_comb begin
    md_dest_s = md_rd;
    md_data_s = md_result;
`ifdef WB_EXCEPTION_EN
    md_dest_s = md_exception ? RW'(STATUS_REG) : md_rd;
    md_data_s = md_exception ? WIDTH'(md_is_div ? ERR_DIV : ERR_MUL) : md_result;
`endif
  end

  assign md_ready   = reset_n & (cq_count_s < CW'(DEPTH));
  assign md_fire_s  = md_valid & md_ready;
  assign cq_empty_s = (cq_count_s == CW'(0));

  // Choose the single write-port source and the queue push/pop for this cycle.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_dest_s  = '0;
    sel_data_s  = '0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    if (pipe_we_s) begin
      sel_valid_s = 1'b1;
      sel_dest_s  = pipe_dest_s;
      sel_data_s  = pipe_data_s;
      push_s      = md_fire_s;
    end else if (!cq_empty_s) begin
      sel_valid_s = head_valid_s;
      sel_dest_s  = head_dest_s;
      sel_data_s  = head_data_s;
      pop_s       = 1'b1;
      push_s      = md_fire_s;
    end else if (md_fire_s) begin
      sel_valid_s = 1'b1;
      sel_dest_s  = md_dest_s;
      sel_data_s  = md_data_s;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  wb_cq #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_cq (
    .clock         (clock),
    .reset_n       (reset_n),
    .push_i        (push_s),
    .push_dest_i   (md_dest_s),
    .push_data_i   (md_data_s),
    .pop_i         (pop_s),
    .squash_i      (pipe_we_s),
    .squash_dest_i (pipe_dest_s),
    .head_valid_o  (head_valid_s),
    .head_dest_o   (head_dest_s),
    .head_data_o   (head_data_s),
    .count_o       (cq_count_s),
    .pending_o     (cq_pending_s)
  );

  // Writes to register 0 are consumed but never reach the register file.
  assign write_ctrl  = reset_n & sel_valid_s & (sel_dest_s != RW'(0));
  assign write_reg   = reset_n ? sel_dest_s : RW'(0);
  assign write_data  = reset_n ? sel_data_s : WIDTH'(0);
  assign loading     = reset_n & pipe_valid & (opcode == OP_LW);
  assign md_pending  = cq_pending_s;
  assign queue_count = cq_count_s;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default parameters).
// Inputs change 1ns after a rising edge; outputs are checked on the falling edge.
module tb_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        pipe_valid;
  logic [4:0]  opcode, alu_op, rd;
  logic [26:0] target;
  logic [31:0] d_in, o_in;
  logic        overflow;
  logic        md_valid, md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_result;
  logic        md_is_div, md_exception;
  logic        write_ctrl;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        loading;
  logic [31:0] md_pending;
  logic [2:0]  queue_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  wb_arbiter dut (
    .clock(clock), .reset_n(reset_n), .pipe_valid(pipe_valid), .opcode(opcode),
    .alu_op(alu_op), .rd(rd), .target(target), .d_in(d_in), .o_in(o_in),
    .overflow(overflow), .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd),
    .md_result(md_result), .md_is_div(md_is_div), .md_exception(md_exception),
    .write_ctrl(write_ctrl), .write_reg(write_reg), .write_data(write_data),
    .loading(loading), .md_pending(md_pending), .queue_count(queue_count)
  );

  task automatic idle();
    pipe_valid = 1'b0; opcode = 5'd0; alu_op = 5'd0; rd = 5'd0; target = 27'd0;
    d_in = 32'd0; o_in = 32'd0; overflow = 1'b0;
    md_valid = 1'b0; md_rd = 5'd0; md_result = 32'd0; md_is_div = 1'b0; md_exception = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pipe(input logic [4:0] op, input logic [4:0] aop, input logic [4:0] r, input logic [31:0] o);
    pipe_valid = 1'b1; opcode = op; alu_op = aop; rd = r; o_in = o;
  endtask

  task automatic md(input logic [4:0] r, input logic [31:0] res);
    md_valid = 1'b1; md_rd = r; md_result = res;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    pipe(5'b01000, 5'd0, 5'd5, 32'd0); d_in = 32'h1111;
    #3;
    n_cmp++; if (write_ctrl !== 1'b0) begin n_err++; $display("FAIL rst_wctrl: got %b want 0", write_ctrl); end
    n_cmp++; if (write_reg !== 5'd0) begin n_err++; $display("FAIL rst_wreg: got %0d want 0", write_reg); end
    n_cmp++; if (write_data !== 32'd0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", write_data); end
    n_cmp++; if (loading !== 1'b0) begin n_err++; $display("FAIL rst_loading: got %b want 0", loading); end
    n_cmp++; if (md_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", md_ready); end
    n_cmp++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", queue_count); end
    step(); step();
    reset_n = 1'b1;
    idle();
    @(negedge clock);
    n_cmp++; if (md_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %b want 1", md_ready); end
    n_cmp++; if (md_pending !== 32'd0) begin n_err++; $display("FAIL rel_pending: got %h want 0", md_pending); end
  endtask

  task automatic test_decode();
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    step();
    pipe(5'b01000, 5'd0, 5'd5, 32'h5555); d_in = 32'hDEAD;
    @(negedge clock);
    n_cmp++; if (write_ctrl !== 1'b1) begin n_err++; $display("FAIL lw_wctrl: got %b want 1", write_ctrl); end
    n_cmp++; if (write_reg !== 5'd5) begin n_err++; $display("FAIL lw_wreg: got %0d want 5", write_reg); end
    n_cmp++; if (write_data !== 32'hDEAD) begin n_err++; $display("FAIL lw_wdata: got %h want dead", write_data); end
    n_cmp++; if (loading !== 1'b1) begin n_err++; $display("FAIL lw_loading: got %b want 1", loading); end
    // addi with overflow
    step(); idle();
    pipe(5'b00101, 5'd0, 5'd4, 32'h1234); overflow = 1'b1;
`ifdef WB_EXCEPTION_EN
    exp_reg = 5'd30; exp_data = 32'd2;
`else
    exp_reg = 5'd4; exp_data = 32'h1234;
`endif
    @(negedge clock);
    n_cmp++; if (write_reg !== exp_reg || write_data !== exp_data) begin n_err++; $display("FAIL addi_ovf: got r%0d %h want r%0d %h", write_reg, write_data, exp_reg, exp_data); end
    n_cmp++; if (loading !== 1'b0) begin n_err++; $display("FAIL addi_loading: got %b want 0", loading); end
    // sub with overflow
    step(); idle();
    pipe(5'b00000, 5'b00001, 5'd6, 32'h0BAD); overflow = 1'b1;
`ifdef WB_EXCEPTION_EN
    exp_reg = 5'd30; exp_data = 32'd3;
`else
    exp_reg = 5'd6; exp_data = 32'h0BAD;
`endif
    @(negedge clock);
    n_cmp++; if (write_reg !== exp_reg || write_data !== exp_data) begin n_err++; $display("FAIL sub_ovf: got r%0d %h want r%0d %h", write_reg, write_data, exp_reg, exp_data); end
    // setx sign-extends a negative target
    step(); idle();
    pipe(5'b10101, 5'd0, 5'd2, 32'h0); target = 27'h4000001;
    @(negedge clock);
    n_cmp++; if (write_ctrl !== 1'b1 || write_reg !== 5'd30 || write_data !== 32'hFC000001) begin n_err++; $display("FAIL setx: got %b r%0d %h want 1 r30 fc000001", write_ctrl, write_reg, write_data); end
    // jal links to r31
    step(); idle();
    pipe(5'b00011, 5'd0, 5'd3, 32'h100);
    @(negedge clock);
    n_cmp++; if (write_ctrl !== 1'b1 || write_reg !== 5'd31 || write_data !== 32'h100) begin n_err++; $display("FAIL jal: got %b r%0d %h want 1 r31 100", write_ctrl, write_reg, write_data); end
    // mul produces no pipe write
    step(); idle();
    pipe(5'b00000, 5'b00110, 5'd8, 32'h7);
    @(negedge clock);
    n_cmp++; if (write_ctrl !== 1'b0) begin n_err++; $display("FAIL mul_nowrite: got %b want 0", write_ctrl); end
    // destination 0 suppressed
    step(); idle();
    pipe(5'b01000, 5'd0, 5'd0, 32'h0); d_in = 32'h77;
    @(negedge clock);
    n_cmp++; if (write_ctrl !== 1'b0) begin n_err++; $display("FAIL r0_write: got %b want 0", write_ctrl); end
  endtask

  task automatic test_md_merge();
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    step(); idle();
    pipe(5'b00000, 5'b00000, 5'd3, 32'h33); md(5'd7, 32'd42);
    @(negedge clock);
    n_cmp++; if (write_ctrl !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'h33) begin n_err++; $display("FAIL merge_pipe: got %b r%0d %h want 1 r3 33", write_ctrl, write_reg, write_data); end
    step(); idle();
    @(negedge clock);
    n_cmp++; if (md_pending[7] !== 1'b1) begin n_err++; $display("FAIL merge_pend: got %b want 1", md_pending[7]); end
    n_cmp++; if (queue_count !== 3'd1) begin n_err++; $display("FAIL merge_count: got %0d want 1", queue_count); end
    n_cmp++; if (write_ctrl !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'd42) begin n_err++; $display("FAIL merge_drain: got %b r%0d %h want 1 r7 2a", write_ctrl, write_reg, write_data); end
    step();
    @(negedge clock);
    n_cmp++; if (queue_count !== 3'd0 || md_pending !== 32'd0 || write_ctrl !== 1'b0) begin n_err++; $display("FAIL merge_after: got cnt %0d pend %h wc %b want 0 0 0", queue_count, md_pending, write_ctrl); end
    // bypass with exception
    step(); idle();
    md(5'd8, 32'd99); md_exception = 1'b1; md_is_div = 1'b1;
`ifdef WB_EXCEPTION_EN
    exp_reg = 5'd30; exp_data = 32'd5;
`else
    exp_reg = 5'd8; exp_data = 32'd99;
`endif
    @(negedge clock);
    n_cmp++; if (write_ctrl !== 1'b1 || write_reg !== exp_reg || write_data !== exp_data) begin n_err++; $display("FAIL bypass: got %b r%0d %h want 1 r%0d %h", write_ctrl, write_reg, write_data, exp_reg, exp_data); end
    step(); idle();
    @(negedge clock);
    n_cmp++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL bypass_count: got %0d want 0", queue_count); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      step(); idle();
      pipe(5'b00000, 5'b00000, 5'd1, 32'(k)); md(5'(10 + k), 32'(100 + k));
    end
    step(); idle();
    pipe(5'b00000, 5'b00000, 5'd1, 32'h9); md(5'd14, 32'd200);
    @(negedge clock);
    n_cmp++; if (queue_count !== 3'd4) begin n_err++; $display("FAIL fill_count: got %0d want 4", queue_count); end
    n_cmp++; if (md_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready: got %b want 0", md_ready); end
    n_cmp++; if (md_pending !== 32'h00003C00) begin n_err++; $display("FAIL fill_pend: got %h want 00003c00", md_pending); end
    step(); idle();
    @(negedge clock);
    n_cmp++; if (queue_count !== 3'd4 || write_reg !== 5'd10 || write_data !== 32'd100) begin n_err++; $display("FAIL fill_head: got cnt %0d r%0d %h want 4 r10 64", queue_count, write_reg, write_data); end
    for (int k = 1; k < 4; k++) begin
      step();
      @(negedge clock);
      n_cmp++; if (queue_count !== 3'(4 - k) || write_ctrl !== 1'b1 || write_reg !== 5'(10 + k) || write_data !== 32'(100 + k)) begin n_err++; $display("FAIL fill_drain%0d: got cnt %0d wc %b r%0d %h want %0d 1 r%0d %h", k, queue_count, write_ctrl, write_reg, write_data, 4 - k, 10 + k, 100 + k); end
      if (k == 1) begin
        n_cmp++; if (md_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_back: got %b want 1", md_ready); end
      end
    end
    step();
    @(negedge clock);
    n_cmp++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL fill_empty: got %0d want 0", queue_count); end
  endtask

  task automatic test_squash();
    step(); idle();
    pipe(5'b00000, 5'b00000, 5'd2, 32'h22); md(5'd9, 32'h99);
    step(); idle();
    pipe(5'b00000, 5'b00000, 5'd9, 32'h77);
    @(negedge clock);
    n_cmp++; if (md_pending[9] !== 1'b1) begin n_err++; $display("FAIL sq_pend_before: got %b want 1", md_pending[9]); end
    n_cmp++; if (write_reg !== 5'd9 || write_data !== 32'h77) begin n_err++; $display("FAIL sq_pipe: got r%0d %h want r9 77", write_reg, write_data); end
    step(); idle();
    @(negedge clock);
    n_cmp++; if (md_pending[9] !== 1'b0) begin n_err++; $display("FAIL sq_pend_after: got %b want 0", md_pending[9]); end
    n_cmp++; if (queue_count !== 3'd1) begin n_err++; $display("FAIL sq_count: got %0d want 1", queue_count); end
    n_cmp++; if (write_ctrl !== 1'b0) begin n_err++; $display("FAIL sq_slot: got %b want 0", write_ctrl); end
    step();
    @(negedge clock);
    n_cmp++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL sq_popped: got %0d want 0", queue_count); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      step(); idle();
      pipe(5'b00000, 5'b00000, 5'd1, 32'h1); md(5'(20 + k), 32'(k));
    end
    step(); idle();
    pipe(5'b01000, 5'd0, 5'd6, 32'h0); d_in = 32'hABCD;
    @(negedge clock);
    n_cmp++; if (queue_count !== 3'd3) begin n_err++; $display("FAIL mid_count: got %0d want 3", queue_count); end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if (write_ctrl !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0 || loading !== 1'b0) begin n_err++; $display("FAIL mid_outs: got %b r%0d %h ld %b want all 0", write_ctrl, write_reg, write_data, loading); end
    n_cmp++; if (queue_count !== 3'd0 || md_pending !== 32'd0 || md_ready !== 1'b0) begin n_err++; $display("FAIL mid_state: got cnt %0d pend %h rdy %b want 0 0 0", queue_count, md_pending, md_ready); end
    step(); idle();
    reset_n = 1'b1;
    @(negedge clock);
    n_cmp++; if (queue_count !== 3'd0 || md_ready !== 1'b1 || write_ctrl !== 1'b0) begin n_err++; $display("FAIL mid_release: got cnt %0d rdy %b wc %b want 0 1 0", queue_count, md_ready, write_ctrl); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_md_merge();
    test_fill();
    test_squash();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Parametrised writeback stage for the five-stage pipeline. It decodes the W-stage instruction into a single register-file write (load data, ALU result, `jal` link, `setx` status, overflow error codes), and merges that write with completions from the multicycle mult/div unit through a DEPTH-entry completion queue. It sits between the MEM/WB latch, the multdiv unit and the register file write port, and exports a pending-destination mask for the hazard unit.

## Interface
Parameters:
- `WIDTH`, 32, datapath width
- `NREGS`, 32, register count; `RW = $clog2(NREGS)`
- `DEPTH`, 4, completion-queue entries (power of two, ≥2)
- `TARGET_W`, 27, `setx` target width, sign-extended to WIDTH
- `LINK_REG`, 31, `jal` destination
- `STATUS_REG`, 30, `setx` / error-code destination

Ports:
- `clock` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `pipe_valid` in 1: W-stage holds a real instruction
- `opcode` in 5, `alu_op` in 5, `rd` in RW, `target` in TARGET_W: W-stage fields
- `d_in` in WIDTH: load data; `o_in` in WIDTH: ALU/PC+1 result; `overflow` in 1
- `md_valid` in 1, `md_ready` out 1: multdiv completion handshake
- `md_rd` in RW, `md_result` in WIDTH, `md_is_div` in 1, `md_exception` in 1
- `write_ctrl` out 1, `write_reg` out RW, `write_data` out WIDTH: regfile write port
- `loading` out 1: W-stage is `lw`
- `md_pending` out NREGS: bit r set while a queued completion targets r
- `queue_count` out $clog2(DEPTH)+1

## Operation
- Pipe decode (gated by `pipe_valid`): `lw`(01000) writes `d_in`→`rd`; R-type(00000), `addi`(00101) write `o_in`→`rd`; `jal`(00011) writes `o_in`→LINK_REG; `setx`(10101) writes sign-extended `target`→STATUS_REG. R-type mul/div (alu_op 00110/00111) produce no pipe write: they complete via the md channel.
- Overflow on add(alu_op 00000)/`addi`/sub(00001): write code 1/2/3 →STATUS_REG instead of rd.
- md completion: `md_exception` writes code 4 (mul) / 5 (div) →STATUS_REG; else `md_result`→`md_rd`.
- Port priority: pipe write > queue head > direct md bypass. Bypass only when queue empty and no pipe write; otherwise accepted md completion is enqueued.
- `md_ready = (queue_count < DEPTH)`; push on `md_valid && md_ready`, no full push-with-pop.
- WAW squash: a pipe write to reg r clears valid on every queue entry whose destination is r, same edge. Squashed head pops in its drain slot with `write_ctrl=0`.
- Any write whose destination is 0 drives `write_ctrl=0` (still pops/consumes).
- `md_pending` = OR over valid entries of one-hot destination; bit 0 always 0.

## Timing
- Pipe path and bypass: combinational, same cycle. Queue drain: head registers to port, pops at that edge.
- md completion enqueued at edge N is drainable in cycle N+1; `md_pending` bit set from N+1 until pop edge.
- `queue_count` updates on edge: +push −pop.
- Reset (`reset_n`=0, async): queue empty, count 0, `md_pending`=0, `md_ready`=0, `write_ctrl`=0, `write_reg`=0, `write_data`=0, `loading`=0 while asserted. Reset mid-queue discards all entries.
- `md_ready` returns 1 the first cycle after deassertion.

## Configuration
- `WB_EXCEPTION_EN` defined: overflow/`md_exception` redirect to STATUS_REG with codes 1–5.
- Undefined: `overflow` and `md_exception` ignored; results write to their normal destination; `setx` unaffected.

## Structure
- Package `wb_pkg`: opcode and alu_op localparams, error-code constants (1–5), queue-entry struct {valid, dest, data}.
- One sub-module: `wb_cq`, the DEPTH-entry circular queue with per-entry squash and pending-mask output.

## Test plan
- `lw` rd=5, d_in=0xDEAD, pipe_valid → write_ctrl=1, reg 5, 0xDEAD, loading=1 same cycle.
- `addi` rd=4 overflow=1 (EN on) → reg 30 data 2; EN off → reg 4 data `o_in`.
- md_valid rd=7 result=42 while `add` rd=3 writes → reg 3 now; reg 7=42 next idle cycle; md_pending[7]=1 between.
- Fill queue to DEPTH with pipe writing every cycle → md_ready=0, count=4; one idle cycle → count 3, md_ready=1.
- Queued completion to reg 9, then pipe writes reg 9 → entry squashed, md_pending[9]=0 next cycle, drain slot write_ctrl=0.
- Assert reset_n=0 with count=3 → outputs zero immediately; after release count=0, md_ready=1.
